// File: rtl/host_cmd_pkg.sv
// rtl/host_cmd_pkg.sv - command words, result codes and FSM states for host_cmd_handler
package host_cmd_pkg;

    localparam logic [15:0] CMD_STATUS      = 16'h0000;
    localparam logic [15:0] CMD_RESET_ENTER = 16'h0010;
    localparam logic [15:0] CMD_RESET_EXIT  = 16'h0011;
    localparam logic [15:0] CMD_DS_READ     = 16'h0080;
    localparam logic [15:0] CMD_DS_WRITE    = 16'h0082;
    localparam logic [15:0] CMD_DS_COMPLETE = 16'h008F;
    localparam logic [15:0] CMD_RTC         = 16'h0090;

    localparam logic [15:0] RES_OK      = 16'h0000;
    localparam logic [15:0] RES_UNKNOWN = 16'h0001;
    localparam logic [15:0] RES_TIMEOUT = 16'h0002;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DS_REQ,
        ST_DS_WAIT,
        ST_DONE,
        ST_DRAIN
    } hcmd_state_e;

endpackage

// File: rtl/host_cmd_handler.sv
// rtl/host_cmd_handler.sv - decodes and executes host bridge commands, forwards data-slot requests
module host_cmd_handler
    import host_cmd_pkg::*;
#(
    parameter logic [31:0] DS_TIMEOUT     = 32'd74_250_000,
    parameter int          PROGRESS_SHIFT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    input  logic [15:0]  cmd_word,
    input  logic [127:0] cmd_param,
    output logic [15:0]  cmd_progress,
    output logic         cmd_done,
    output logic [15:0]  cmd_result,
    output logic [31:0]  cmd_response,
    input  logic [1:0]   core_status,
    output logic         core_reset,
    output logic         ds_req_valid,
    output logic         ds_req_write,
    output logic [15:0]  ds_req_slot,
    output logic [31:0]  ds_req_param,
    input  logic         ds_req_ready,
    input  logic         ds_resp_valid,
    input  logic [15:0]  ds_resp_result,
    output logic         ds_all_complete,
    output logic         rtc_valid,
    output logic [31:0]  rtc_epoch,
    output logic [31:0]  rtc_date,
    output logic [31:0]  rtc_time
);

    hcmd_state_e state_q, state_d;
    logic [31:0] counter_q, counter_d;
    logic [15:0] result_d, progress_d;
    logic        core_reset_d, ds_req_valid_d, ds_req_write_d;
    logic [15:0] ds_req_slot_d;
    logic [31:0] ds_req_param_d, rtc_epoch_d, rtc_date_d, rtc_time_d;
    logic        ds_all_complete_d, rtc_valid_d;
    logic        timeout, in_ds;
    logic [31:0] word0, word1, word2;
    logic        unused_param;

    assign word0        = cmd_param[127:96];
    assign word1        = cmd_param[95:64];
    assign word2        = cmd_param[63:32];
    assign unused_param = &{1'b0, cmd_param[31:0]};
    assign in_ds        = (state_q == ST_DS_REQ) || (state_q == ST_DS_WAIT);
    assign timeout      = (counter_q == DS_TIMEOUT - 32'd1);

    always_comb begin
        state_d           = state_q;
        counter_d         = counter_q;
        result_d          = cmd_result;
        core_reset_d      = core_reset;
        ds_req_valid_d    = ds_req_valid;
        ds_req_write_d    = ds_req_write;
        ds_req_slot_d     = ds_req_slot;
        ds_req_param_d    = ds_req_param;
        rtc_epoch_d       = rtc_epoch;
        rtc_date_d        = rtc_date;
        rtc_time_d        = rtc_time;
        ds_all_complete_d = 1'b0;
        rtc_valid_d       = 1'b0;
        progress_d        = in_ds ? counter_q[PROGRESS_SHIFT+15:PROGRESS_SHIFT] : 16'd0;

        // saturating elapsed-cycle count while a data-slot command is in flight
        if (in_ds && counter_q != 32'hFFFF_FFFF)
            counter_d = counter_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_DONE;
                    case (cmd_word)
                        CMD_STATUS:      result_d = {14'b0, core_status};
                        CMD_RESET_ENTER: begin core_reset_d = 1'b1; result_d = RES_OK; end
                        CMD_RESET_EXIT:  begin core_reset_d = 1'b0; result_d = RES_OK; end
                        CMD_DS_COMPLETE: begin ds_all_complete_d = 1'b1; result_d = RES_OK; end
                        CMD_RTC: begin
                            rtc_epoch_d = word0;
                            rtc_date_d  = word1;
                            rtc_time_d  = word2;
                            rtc_valid_d = 1'b1;
                            result_d    = RES_OK;
                        end
                        CMD_DS_READ, CMD_DS_WRITE: begin
                            ds_req_valid_d = 1'b1;
                            ds_req_write_d = (cmd_word == CMD_DS_WRITE);
                            ds_req_slot_d  = word0[15:0];
                            ds_req_param_d = word1;
                            counter_d      = 32'd0;
                            state_d        = ST_DS_REQ;
                        end
                        default:         result_d = RES_UNKNOWN;
                    endcase
                end
            end
            ST_DS_REQ: begin
                // a response arriving with ready beats a coincident timeout
                if (ds_req_ready && ds_resp_valid) begin
                    ds_req_valid_d = 1'b0;
                    result_d       = ds_resp_result;
                    state_d        = ST_DONE;
                end else if (timeout) begin
                    ds_req_valid_d = 1'b0;
                    result_d       = RES_TIMEOUT;
                    state_d        = ST_DONE;
                end else if (ds_req_ready) begin
                    ds_req_valid_d = 1'b0;
                    state_d        = ST_DS_WAIT;
                end
            end
            ST_DS_WAIT: begin
                if (ds_resp_valid) begin
                    result_d = ds_resp_result;
                    state_d  = ST_DONE;
                end else if (timeout) begin
                    result_d = RES_TIMEOUT;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DRAIN;
            ST_DRAIN: if (!cmd_valid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            counter_q       <= 32'd0;
            cmd_progress    <= 16'd0;
            cmd_done        <= 1'b0;
            cmd_result      <= 16'd0;
            cmd_response    <= 32'd0;
            core_reset      <= 1'b1;
            ds_req_valid    <= 1'b0;
            ds_req_write    <= 1'b0;
            ds_req_slot     <= 16'd0;
            ds_req_param    <= 32'd0;
            ds_all_complete <= 1'b0;
            rtc_valid       <= 1'b0;
            rtc_epoch       <= 32'd0;
            rtc_date        <= 32'd0;
            rtc_time        <= 32'd0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            cmd_progress    <= progress_d;
            cmd_done        <= (state_d == ST_DONE);
            cmd_result      <= result_d;
            cmd_response    <= 32'd0;
            core_reset      <= core_reset_d;
            ds_req_valid    <= ds_req_valid_d;
            ds_req_write    <= ds_req_write_d;
            ds_req_slot     <= ds_req_slot_d;
            ds_req_param    <= ds_req_param_d;
            ds_all_complete <= ds_all_complete_d;
            rtc_valid       <= rtc_valid_d;
            rtc_epoch       <= rtc_epoch_d;
            rtc_date        <= rtc_date_d;
            rtc_time        <= rtc_time_d;
        end
    end

endmodule

// File: tb/tb_host_cmd_handler.sv
// tb/tb_host_cmd_handler.sv - directed self-checking bench for host_cmd_handler
module tb_host_cmd_handler;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic [15:0]  cmd_word;
    logic [127:0] cmd_param;
    logic [15:0]  cmd_progress;
    logic         cmd_done;
    logic [15:0]  cmd_result;
    logic [31:0]  cmd_response;
    logic [1:0]   core_status;
    logic         core_reset;
    logic         ds_req_valid;
    logic         ds_req_write;
    logic [15:0]  ds_req_slot;
    logic [31:0]  ds_req_param;
    logic         ds_req_ready;
    logic         ds_resp_valid;
    logic [15:0]  ds_resp_result;
    logic         ds_all_complete;
    logic         rtc_valid;
    logic [31:0]  rtc_epoch;
    logic [31:0]  rtc_date;
    logic [31:0]  rtc_time;

    int checks = 0;
    int errors = 0;
    int pulses;

    host_cmd_handler #(.DS_TIMEOUT(32'd100), .PROGRESS_SHIFT(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_word(cmd_word), .cmd_param(cmd_param),
        .cmd_progress(cmd_progress), .cmd_done(cmd_done), .cmd_result(cmd_result),
        .cmd_response(cmd_response), .core_status(core_status), .core_reset(core_reset),
        .ds_req_valid(ds_req_valid), .ds_req_write(ds_req_write), .ds_req_slot(ds_req_slot),
        .ds_req_param(ds_req_param), .ds_req_ready(ds_req_ready), .ds_resp_valid(ds_resp_valid),
        .ds_resp_result(ds_resp_result), .ds_all_complete(ds_all_complete),
        .rtc_valid(rtc_valid), .rtc_epoch(rtc_epoch), .rtc_date(rtc_date), .rtc_time(rtc_time)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_cmd();
        cmd_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_word = 16'h0; cmd_param = 128'h0;
        core_status = 2'd3; ds_req_ready = 1'b0; ds_resp_valid = 1'b0; ds_resp_result = 16'h0;
        tick(); tick();
        check("rst_core_reset", core_reset, 1);
        check("rst_done", cmd_done, 0);
        check("rst_result", cmd_result, 0);
        check("rst_progress", cmd_progress, 0);
        check("rst_ds_req_valid", ds_req_valid, 0);
        check("rst_strobes", {rtc_valid, ds_all_complete}, 0);
        reset_n = 1'b1;
        tick();

        // status
        cmd_valid = 1'b1; cmd_word = 16'h0000;
        check("status_done_before", cmd_done, 0);
        tick();
        check("status_done", cmd_done, 1);
        check("status_result", cmd_result, 16'h0003);
        check("status_response", cmd_response, 0);
        finish_cmd();
        check("status_done_after", cmd_done, 0);

        // core reset exit / enter
        cmd_valid = 1'b1; cmd_word = 16'h0011;
        tick();
        check("exit_core_reset", core_reset, 0);
        check("exit_result", cmd_result, 0);
        check("exit_done", cmd_done, 1);
        finish_cmd();
        cmd_valid = 1'b1; cmd_word = 16'h0010;
        tick();
        check("enter_core_reset", core_reset, 1);
        finish_cmd();

        // all-complete pulse
        cmd_valid = 1'b1; cmd_word = 16'h008F;
        tick();
        check("allc_pulse", ds_all_complete, 1);
        check("allc_done", cmd_done, 1);
        tick();
        check("allc_pulse_end", ds_all_complete, 0);
        finish_cmd();

        // RTC latch
        cmd_valid = 1'b1; cmd_word = 16'h0090;
        cmd_param = {32'h6543_2100, 32'h0020_2401, 32'h0012_3456, 32'h0};
        tick();
        check("rtc_valid", rtc_valid, 1);
        check("rtc_epoch", rtc_epoch, 32'h6543_2100);
        check("rtc_date", rtc_date, 32'h0020_2401);
        check("rtc_time", rtc_time, 32'h0012_3456);
        check("rtc_done", cmd_done, 1);
        tick();
        check("rtc_valid_end", rtc_valid, 0);
        finish_cmd();

        // data-slot write, ready after 3 cycles, response later
        cmd_valid = 1'b1; cmd_word = 16'h0082;
        cmd_param = {32'h0000_0005, 32'hCAFE_0001, 64'h0};
        tick();
        check("dsw_valid", ds_req_valid, 1);
        check("dsw_write", ds_req_write, 1);
        check("dsw_slot", ds_req_slot, 16'h0005);
        check("dsw_param", ds_req_param, 32'hCAFE_0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dsw_hold", {ds_req_valid, ds_req_slot, ds_req_param}, {1'b1, 16'h0005, 32'hCAFE_0001});
        end
        ds_req_ready = 1'b1;
        tick();
        ds_req_ready = 1'b0;
        check("dsw_valid_drop", ds_req_valid, 0);
        for (int i = 0; i < 9; i++) tick();
        check("dsw_no_done_yet", cmd_done, 0);
        ds_resp_valid = 1'b1; ds_resp_result = 16'h0000;
        tick();
        ds_resp_valid = 1'b0;
        check("dsw_done", cmd_done, 1);
        check("dsw_result", cmd_result, 16'h0000);
        tick();
        check("dsw_done_end", cmd_done, 0);
        finish_cmd();

        // data-slot read, response coincides with ready
        cmd_valid = 1'b1; cmd_word = 16'h0080;
        cmd_param = {32'h0000_0007, 32'h1111_2222, 64'h0};
        tick();
        check("dsr_write", ds_req_write, 0);
        check("dsr_slot", ds_req_slot, 16'h0007);
        ds_req_ready = 1'b1; ds_resp_valid = 1'b1; ds_resp_result = 16'h00A5;
        tick();
        ds_req_ready = 1'b0; ds_resp_valid = 1'b0;
        check("dsr_done", cmd_done, 1);
        check("dsr_result", cmd_result, 16'h00A5);
        check("dsr_valid_drop", ds_req_valid, 0);
        finish_cmd();

        // timeout with no ready or response
        cmd_valid = 1'b1; cmd_word = 16'h0080;
        cmd_param = {32'h0000_0009, 96'h0};
        tick();
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (t == 8)  check("to_progress_8", cmd_progress, 16'd1);
            if (t == 97) check("to_progress_97", cmd_progress, 16'd24);
            if (t == 99) check("to_no_done_99", cmd_done, 0);
        end
        check("to_done", cmd_done, 1);
        check("to_result", cmd_result, 16'h0002);
        check("to_valid_drop", ds_req_valid, 0);
        ds_resp_valid = 1'b1; ds_resp_result = 16'h0055;
        tick();
        ds_resp_valid = 1'b0;
        check("late_resp_result", cmd_result, 16'h0002);
        check("late_resp_done", cmd_done, 0);
        check("to_progress_clear", cmd_progress, 0);
        finish_cmd();

        // unknown command held high after done
        cmd_valid = 1'b1; cmd_word = 16'h1234;
        tick();
        check("unk_result", cmd_result, 16'h0001);
        pulses = cmd_done ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cmd_done) pulses++;
        end
        check("unk_one_done", pulses, 1);
        finish_cmd();

        // reset during DS_WAIT
        cmd_valid = 1'b1; cmd_word = 16'h0082;
        cmd_param = {32'h0000_0003, 96'h0};
        tick();
        ds_req_ready = 1'b1;
        tick();
        ds_req_ready = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        check("mid_progress", cmd_progress, 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_strobes", {ds_req_valid, cmd_done, rtc_valid, ds_all_complete}, 0);
        check("mid_rst_progress", cmd_progress, 0);
        check("mid_rst_core_reset", core_reset, 1);
        cmd_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        cmd_valid = 1'b1; cmd_word = 16'h0000; core_status = 2'd2;
        tick();
        check("post_rst_done", cmd_done, 1);
        check("post_rst_result", cmd_result, 16'h0002);
        finish_cmd();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_cmd_handler.md
Name: host_cmd_handler

Overview:
- Consumes host-originated commands presented on the cmd side of bridge_driver_if by the bridge register driver.
- Decodes each command word and executes it:
  - immediate commands: status, core reset control, RTC latch;
  - data-slot commands: forwarded to a downstream data-slot engine over a valid/ready request and a response pulse.
- Returns result, response and running progress to the driver, then pulses done.
- Sits between the bridge register driver and core-side control logic.

Parameters:
- DS_TIMEOUT, 32'd74_250_000, cycles allowed for a data-slot command (request plus response) before it is failed.
- PROGRESS_SHIFT, 16, right shift applied to the elapsed-cycle counter to form cmd.progress.

Ports:
- clk  in  1  bridge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd  bridge_driver_if  -  block reads valid/word/param; drives progress/done/result/response.
- core_status  in  2  1=booting, 2=setup, 3=running.
- core_reset  out  1  core reset request, held.
- ds_req_valid  out  1  data-slot request valid.
- ds_req_write  out  1  0=read (0x0080), 1=write (0x0082).
- ds_req_slot  out  16  slot id, from param word0[15:0].
- ds_req_param  out  32  param word1.
- ds_req_ready  in  1  downstream accepts request.
- ds_resp_valid  in  1  one-cycle completion pulse.
- ds_resp_result  in  16  completion code.
- ds_all_complete  out  1  one-cycle pulse on command 0x008F.
- rtc_valid  out  1  one-cycle pulse on command 0x0090.
- rtc_epoch  out  32  RTC epoch seconds.
- rtc_date  out  32  RTC date (BCD).
- rtc_time  out  32  RTC time (BCD).

Behaviour:
- Param word n is param[127-32n -: 32] (word0 = MSBs). Word values are raw, unswapped.
- Reset values:
  - core_reset=1.
  - done=0, progress=0, result=0, response=0.
  - ds_req_valid=0, ds_all_complete=0, rtc_valid=0.
  - rtc_* and ds_req_* data=0.
  - State IDLE, counter=0.
- All outputs are registered.
- States: IDLE, DS_REQ, DS_WAIT, DONE, DRAIN.
- IDLE, on valid=1 at cycle N: latch word/param and decode.
  - 0x0000: result={14'b0,core_status}. Next state DONE.
  - 0x0010: core_reset<=1, result=OK. Next state DONE.
  - 0x0011: core_reset<=0, result=OK. Next state DONE.
  - 0x008F: pulse ds_all_complete at N+1, result=OK. Next state DONE.
  - 0x0090: load rtc_epoch/date/time from words 0/1/2, pulse rtc_valid at N+1, result=OK. Next state DONE.
  - 0x0080 / 0x0082: drive ds_req_*, set ds_req_valid=1, counter=0. Next state DS_REQ.
  - Any other word: result=RES_UNKNOWN. Next state DONE.
- DONE: done=1 for exactly one cycle, so immediate commands assert done at N+1. Next state DRAIN.
- DRAIN: wait for valid=0, then go to IDLE. A valid held high after done is never re-executed.
- DS_REQ:
  - Hold ds_req_valid and data stable until ds_req_ready=1, then drop valid and go to DS_WAIT.
  - If ds_resp_valid coincides with ready, take the response and go straight to DONE.
- DS_WAIT: on ds_resp_valid, result=ds_resp_result, go to DONE.
- Counter:
  - Increments every cycle in DS_REQ/DS_WAIT.
  - progress <= counter[PROGRESS_SHIFT+15:PROGRESS_SHIFT]; progress=0 in other states.
  - Saturates; never wraps.
- Timeout: when counter reaches DS_TIMEOUT-1 in DS_REQ/DS_WAIT:
  - result=RES_TIMEOUT, ds_req_valid<=0, go to DONE.
  - A ds_resp_valid in the same cycle wins over the timeout.
  - A late ds_resp_valid arriving in DONE/DRAIN/IDLE is ignored.
- response is all zero for every command. result is held until the next decode.
- Reset asserted mid-operation: return to IDLE immediately and drop all strobes.
  - If valid is still high on reset release, it is treated as a new command.

Decomposition:
- Package host_cmd_pkg holds:
  - cmd word constants: CMD_STATUS, CMD_RESET_ENTER, CMD_RESET_EXIT, CMD_DS_READ, CMD_DS_WRITE, CMD_DS_COMPLETE, CMD_RTC;
  - result codes: RES_OK=16'h0000, RES_UNKNOWN=16'h0001, RES_TIMEOUT=16'h0002;
  - the hcmd_state_e enum.
- No sub-module; one FSM plus the counter.

Test Plan:
- core_status=3; valid word=0x0000 at N -> done=1 only at N+1, result=16'h0003, response=0.
- word 0x0011 after reset -> core_reset 1->0 at N+1, result=0. Then word 0x0010 -> core_reset=1.
- word 0x0090 with words 0/1/2 = 0x6543_2100, 0x0020_2401, 0x0012_3456 -> rtc_valid for 1 cycle, rtc_* equal those values, done=1.
- word 0x0082, param word0=0x0000_0005; ready delayed 3 cycles; resp_valid with result 0x0000 after 10 cycles:
  - ds_req_write=1, ds_req_slot=5, valid held stable until ready;
  - done on the cycle after resp, result=0.
- DS_TIMEOUT=100, PROGRESS_SHIFT=2, word 0x0080, no response:
  - progress ramps (24 at counter 96);
  - done with result=0x0002 after 100 cycles;
  - late resp_valid ignored.
- word 0x1234 held high 5 cycles after done -> result=0x0001, exactly one done pulse. Reset mid-DS_WAIT -> all strobes 0, state IDLE.
